disp_scan_ctrl: RTL and testbench

Sequencer for the DISP colour-lookup unit. On a start pulse it walks a ROWS x COLS result matrix in row-major order. For each element it fetches a 9-bit colour index from matrix memory, presents it to the colour-lookup unit, and registers the returned 24-bit RGB. It then emits the pixel on a valid/ready stream toward the display/framebuffer writer, tagged with x/y coordinates and a last flag.

---
 rtl/disp_scan_ctrl.sv | 156 +++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: frame scan sequencer for the DISP colour lookup.
// Fetch index, look up RGB, emit one tagged pixel per element.
module disp_scan_ctrl #(
  parameter  int COLS   = 16,
  parameter  int ROWS   = 16,
  parameter  int ADDR_W = 8,
  localparam int XW     = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int YW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [8:0]        mem_data,
  output logic [8:0]        colour_index,
  input  logic [23:0]       rgb,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [23:0]       pix_data,
  output logic [XW-1:0]     pix_x,
  output logic [YW-1:0]     pix_y,
  output logic              pix_last
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOOKUP,
    S_EMIT,
    S_DONE
  } state_e;

  localparam logic [XW-1:0] XMAX = XW'(COLS - 1);
  localparam logic [YW-1:0] YMAX = YW'(ROWS - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic              busy_q;
  logic              done_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [8:0]        ci_q;
  logic              pv_q;
  logic [23:0]       pd_q;
  logic [XW-1:0]     px_q;
  logic [YW-1:0]     py_q;
  logic              plast_q;

  logic [XW-1:0]     x_d;
  logic [YW-1:0]     y_d;
  logic [ADDR_W-1:0] addr_d;
  logic              last_c;
  int                lin_c;

  // Row-major successor of (x,y) and its wrapped word address.
  always_comb begin
    last_c = (x_q == XMAX) && (y_q == YMAX);
    x_d    = x_q + 1'b1;
    y_d    = y_q;
    if (x_q == XMAX) begin
      x_d = '0;
      y_d = y_q + 1'b1;
    end
    lin_c  = int'(y_d) * COLS + int'(x_d);
    addr_d = base_q + ADDR_W'(lin_c);
  end

  // Scan FSM; every output is a register written here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      ci_q    <= '0;
      pv_q    <= 1'b0;
      pd_q    <= '0;
      px_q    <= '0;
      py_q    <= '0;
      plast_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            base_q  <= base_addr;
            addr_q  <= base_addr;
            x_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b1;
            req_q   <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (mem_valid) begin
            ci_q    <= mem_data;
            req_q   <= 1'b0;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          pd_q    <= rgb;
          px_q    <= x_q;
          py_q    <= y_q;
          plast_q <= last_c;
          pv_q    <= 1'b1;
          state_q <= S_EMIT;
        end
        S_EMIT: begin
          if (pix_ready) begin
            pv_q <= 1'b0;
            if (plast_q) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              x_q     <= x_d;
              y_q     <= y_d;
              addr_q  <= addr_d;
              req_q   <= 1'b1;
              state_q <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign mem_req      = req_q;
  assign mem_addr     = addr_q;
  assign colour_index = ci_q;
  assign pix_valid    = pv_q;
  assign pix_data     = pd_q;
  assign pix_x        = px_q;
  assign pix_y        = py_q;
  assign pix_last     = plast_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: scoreboard bench for disp_scan_ctrl.
// Random memory, latency, back-pressure, spurious starts/valids.
module tb_disp_scan_ctrl;
  localparam int COLS = 3;
  localparam int ROWS = 2;
  localparam int AW   = 8;
  localparam int N    = COLS * ROWS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start;
  logic [AW-1:0] base_addr;
  logic          busy, done, mem_req, mem_valid;
  logic [AW-1:0] mem_addr;
  logic [8:0]    mem_data, colour_index;
  logic [23:0]   rgb, pix_data;
  logic          pix_valid, pix_ready, pix_last;
  logic [1:0]    pix_x;
  logic [0:0]    pix_y;

  logic          start1;
  logic [AW-1:0] base1, addr1;
  logic          busy1, done1, req1, valid1;
  logic [8:0]    data1, ci1;
  logic [23:0]   rgb1, pd1;
  logic          pv1, rdy1, last1;
  logic [0:0]    px1, py1;

  function automatic logic [23:0] palette(input logic [8:0] i);
    case (i)
      9'd0:    palette = 24'hffffff;
      9'd1:    palette = 24'hff0080;
      9'd9:    palette = 24'hff0d77;
      9'd505:  palette = 24'h0000ff;
      9'd511:  palette = 24'hffffff;
      default: palette = {i[8:1], i[7:0] ^ 8'h5a, ~i[7:0]};
    endcase
  endfunction

  assign rgb    = palette(colour_index);
  assign rgb1   = palette(ci1);
  assign valid1 = req1;
  assign data1  = 9'd505;
  assign rdy1   = 1'b1;

  disp_scan_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_data(mem_data),
    .colour_index(colour_index), .rgb(rgb),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last)
  );

  disp_scan_ctrl #(.COLS(1), .ROWS(1), .ADDR_W(AW)) u_one (
    .clk(clk), .rst_n(rst_n), .start(start1), .base_addr(base1),
    .busy(busy1), .done(done1), .mem_req(req1), .mem_addr(addr1),
    .mem_valid(valid1), .mem_data(data1),
    .colour_index(ci1), .rgb(rgb1),
    .pix_valid(pv1), .pix_ready(rdy1), .pix_data(pd1),
    .pix_x(px1), .pix_y(py1), .pix_last(last1)
  );

  typedef struct {
    logic [23:0] rgb;
    int          x;
    int          y;
    bit          last;
  } pix_t;

  pix_t          exp_pix[$];
  logic [AW-1:0] exp_addr[$];
  logic [8:0]    mem[256];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int lat_max = 0;
  bit force_ready = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory responder: random latency, spurious valids when idle.
  initial begin
    int cnt;
    cnt = -1;
    mem_valid = 1'b0;
    mem_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt = -1;
        mem_valid = 1'b0;
      end else if (mem_req) begin
        if (cnt < 0) cnt = $urandom_range(0, lat_max);
        if (cnt == 0) begin
          mem_valid = 1'b1;
          mem_data = mem[mem_addr];
          cnt = -1;
        end else begin
          cnt--;
          mem_valid = 1'b0;
          mem_data = 9'($urandom);
        end
      end else begin
        cnt = -1;
        mem_valid = ($urandom % 4 == 0);
        mem_data = 9'($urandom);
      end
    end
  end

  // Pixel sink: random ready with occasional 5-cycle stalls.
  initial begin
    int stall;
    stall = 0;
    pix_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (force_ready) pix_ready = 1'b1;
      else if (stall > 0) begin
        pix_ready = 1'b0;
        stall--;
      end else if ($urandom % 12 == 0) begin
        pix_ready = 1'b0;
        stall = 4;
      end else pix_ready = ($urandom % 4 != 0);
    end
  end

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    logic          p_req, p_pv, p_last, p_done, hs;
    logic [AW-1:0] p_addr;
    logic [8:0]    p_ci;
    logic [23:0]   p_data;
    logic [1:0]    p_x;
    logic [0:0]    p_y;
    pix_t          e;
    {p_req, p_pv, p_last, p_done, p_addr, p_ci, p_data, p_x, p_y} = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        chk("reset_outputs",
            {31'd0, |{busy, done, mem_req, mem_addr, colour_index, pix_valid,
                      pix_data, pix_x, pix_y, pix_last}}, 32'd0);
        {p_req, p_pv, p_last, p_done, p_addr, p_ci, p_data, p_x, p_y} = '0;
      end else begin
        if (mem_req && !p_req) begin
          if (exp_addr.size() == 0) chk("unexpected_mem_req", 32'd1, 32'd0);
          else chk("mem_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
        end
        if (mem_req && p_req) chk("addr_hold", 32'(mem_addr), 32'(p_addr));
        if (p_req && mem_valid) begin
          chk("ci_capture", 32'(colour_index), 32'(mem_data));
          chk("req_drop", 32'(mem_req), 32'd0);
        end else if (colour_index != p_ci)
          chk("ci_spurious", 32'(colour_index), 32'(p_ci));
        hs = p_pv && pix_ready;
        if (hs) begin
          hs_cnt++;
          if (exp_pix.size() == 0) chk("unexpected_pixel", 32'd1, 32'd0);
          else begin
            e = exp_pix.pop_front();
            chk("pix_data", 32'(p_data), 32'(e.rgb));
            chk("pix_x", 32'(p_x), e.x);
            chk("pix_y", 32'(p_y), e.y);
            chk("pix_last", 32'(p_last), 32'(e.last));
          end
          chk("pv_drop", 32'(pix_valid), 32'd0);
        end
        if (done || (hs && p_last)) begin
          chk("done_pulse", 32'(done), 32'(hs && p_last));
          chk("busy_in_done", 32'(busy), 32'd1);
          if (done) begin
            done_cnt++;
            done_cyc = cyc;
          end
        end
        if (p_done) chk("busy_clear", 32'(busy), 32'd0);
        if (p_pv && !pix_ready) begin
          chk("stall_valid", 32'(pix_valid), 32'd1);
          chk("stall_hold", {4'd0, pix_data, pix_x, pix_y, pix_last},
              {4'd0, p_data, p_x, p_y, p_last});
        end
        if (pix_valid) chk("no_req_in_emit", 32'(mem_req), 32'd0);
        p_req  = mem_req;
        p_addr = mem_addr;
        p_ci   = colour_index;
        p_pv   = pix_valid;
        p_data = pix_data;
        p_x    = pix_x;
        p_y    = pix_y;
        p_last = pix_last;
        p_done = done;
      end
    end
  end

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = 9'($urandom);
  endtask

  // Issue a start and push the frame the model expects.
  task automatic kick(input logic [AW-1:0] b, output int c0);
    logic [AW-1:0] a;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      a = b + AW'(i);
      exp_addr.push_back(a);
      exp_pix.push_back('{palette(mem[a]), i % COLS, i / COLS, i == N - 1});
    end
    start = 1'b1;
    base_addr = b;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    base_addr = AW'($urandom);
  endtask

  task automatic run_frame(input logic [AW-1:0] b, input bit spur,
                           input bit sdone, output int cycles);
    int  c0, d0;
    bit  got;
    d0 = done_cnt;
    kick(b, c0);
    got = 1'b0;
    cycles = -1;
    for (int k = 0; k < 3000 && !got; k++) begin
      if (done_cnt > d0) got = 1'b1;
      else begin
        if (spur && exp_pix.size() > 0 && $urandom % 8 == 0) begin
          start = 1'b1;
          base_addr = AW'($urandom);
        end else start = 1'b0;
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (!got) chk("frame_timeout", 32'd1, 32'd0);
    else begin
      cycles = done_cyc - c0;
      if (sdone) begin
        start = 1'b1;
        base_addr = AW'($urandom);
        @(negedge clk);
        start = 1'b0;
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic reset_mid_scan();
    int c0, h0;
    bit got;
    fill_mem();
    lat_max = 2;
    force_ready = 1'b0;
    h0 = hs_cnt;
    kick(AW'($urandom), c0);
    got = 1'b0;
    for (int k = 0; k < 500 && !got; k++) begin
      if (hs_cnt >= h0 + 2) got = 1'b1;
      else begin
        if ($urandom % 6 == 0) start = 1'b1;
        else start = 1'b0;
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (!got) chk("reset_wait_timeout", 32'd1, 32'd0);
    rst_n = 1'b0;
    exp_pix.delete();
    exp_addr.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic one_pixel();
    bit found;
    @(negedge clk);
    start1 = 1'b1;
    base1 = 8'h33;
    @(negedge clk);
    start1 = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk);
      #1;
      if (pv1) found = 1'b1;
    end
    chk("one_found", 32'(found), 32'd1);
    chk("one_last", 32'(last1), 32'd1);
    chk("one_xy", {30'd0, px1, py1}, 32'd0);
    chk("one_data", 32'(pd1), 32'h0000ff);
    @(posedge clk);
    #1;
    chk("one_done", 32'(done1), 32'd1);
    chk("one_pv_drop", 32'(pv1), 32'd0);
    @(posedge clk);
    #1;
    chk("one_busy_clear", 32'(busy1), 32'd0);
    chk("one_done_pulse", 32'(done1), 32'd0);
  endtask

  initial begin
    int cyc_n;
    start = 1'b0;
    base_addr = '0;
    start1 = 1'b0;
    base1 = '0;
    fill_mem();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    mem[8'h10] = 9'd0;
    mem[8'h11] = 9'd1;
    mem[8'h12] = 9'd9;
    mem[8'h13] = 9'd511;
    mem[8'h14] = 9'd505;
    mem[8'h15] = 9'd9;
    lat_max = 0;
    force_ready = 1'b1;
    run_frame(8'h10, 1'b0, 1'b0, cyc_n);
    chk("min_frame_cycles", cyc_n, 3 * N + 1);

    fill_mem();
    lat_max = 4;
    force_ready = 1'b0;
    run_frame(8'hfe, 1'b1, 1'b1, cyc_n);

    for (int f = 0; f < 25; f++) begin
      fill_mem();
      lat_max = $urandom_range(0, 4);
      force_ready = ($urandom % 4 == 0);
      run_frame(AW'($urandom), 1'b1, ($urandom % 2 == 0), cyc_n);
    end

    reset_mid_scan();
    fill_mem();
    lat_max = 3;
    force_ready = 1'b0;
    run_frame(AW'($urandom), 1'b1, 1'b0, cyc_n);

    one_pixel();

    chk("queues_empty", exp_pix.size() + exp_addr.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
